// File: rtl/aes_ctr_ctrl_if.sv
// Block-side streams of the CTR sequencer: data in, result out, and the encipher handshake.
// master = controller view; slave = data source/sink and encipher block.
interface aes_ctr_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         enc_next;
  logic [127:0] enc_block;
  logic         enc_ready;
  logic [127:0] enc_result;

  modport master (
    input  in_valid, in_data, out_ready, enc_ready, enc_result,
    output in_ready, out_valid, out_data, enc_next, enc_block
  );

  modport slave (
    output in_valid, in_data, out_ready, enc_ready, enc_result,
    input  in_ready, out_valid, out_data, enc_next, enc_block
  );
endinterface

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencer: one block in flight, result = data ^ E(ctr); AES_CTR_ABORT_EN adds abort_i.
// Latency: encipher latency + 2 cycles per block; out_valid holds until out_ready, no launch meanwhile.
module aes_ctr_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [127:0]   init_ctr_i,
  input  logic [15:0]    num_blocks_i,
  input  logic           key_ready_i,
`ifdef AES_CTR_ABORT_EN
  input  logic           abort_i,
`endif
  aes_ctr_ctrl_if.master bus,
  output logic [127:0]   ctr_value_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [1:0] {IDLE, LAUNCH, KS, OUT} state_e;

  // Only the low CTR_WIDTH bits count; the rest is nonce.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

  state_e       state_q, state_d;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_q, out_d;
  logic [15:0]  rem_q, rem_d;
  logic         have_q, have_d;
  logic         done_q, done_d;
  logic         abort_hit;
  logic         in_rdy;
  logic         xfer;
  logic [127:0] ctr_inc;
  logic [127:0] ks_src;

`ifdef AES_CTR_ABORT_EN
  logic abort_pend_q, abort_pend_d;

  assign abort_hit = abort_pend_q | abort_i;

  always_comb begin
    abort_pend_d = (state_q != IDLE) && (state_d != IDLE) && abort_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_pend_q <= 1'b0;
    end else begin
      abort_pend_q <= abort_pend_d;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  assign xfer    = bus.in_valid & in_rdy;
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
  assign ks_src  = have_q ? data_q : bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      have_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      data_q  <= data_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      have_q  <= have_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    data_d  = data_q;
    out_d   = out_q;
    rem_d   = rem_q;
    have_d  = have_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && key_ready_i) begin
          ctr_d = init_ctr_i;
          rem_d = num_blocks_i;
          if (num_blocks_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        have_d  = xfer;
        if (xfer) data_d = bus.in_data;
        state_d = KS;
      end
      KS: begin
        if (xfer) begin
          data_d = bus.in_data;
          have_d = 1'b1;
        end
        // The encipher block cannot be cancelled, so an abort still waits for ready.
        if (bus.enc_ready) begin
          if (abort_hit) begin
            state_d = IDLE;
            have_d  = 1'b0;
            done_d  = 1'b1;
          end else if (have_q || xfer) begin
            out_d   = ks_src ^ bus.enc_result;
            have_d  = 1'b0;
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (abort_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.out_ready) begin
          ctr_d = ctr_inc;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rdy        = 1'b0;
    bus.out_valid = 1'b0;
    bus.enc_next  = 1'b0;
    case (state_q)
      LAUNCH: begin
        bus.enc_next = 1'b1;
        in_rdy       = !have_q && !abort_hit;
      end
      KS:      in_rdy = !have_q && !abort_hit;
      OUT:     bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = out_q;
  assign bus.enc_block = ctr_q;
  assign ctr_value_o   = ctr_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// Bench for aes_ctr_ctrl: AES-128 encipher model, random source/sink, scoreboard of expected results.
module tb_aes_ctr_ctrl;
  localparam int CW = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         key_ready = 1'b1;
  logic [127:0] init_ctr = '0;
  logic [15:0]  num_blocks = '0;
  logic [127:0] ctr_value;
  logic         busy;
  logic         done;
`ifdef AES_CTR_ABORT_EN
  logic         abort = 1'b0;
`endif

  aes_ctr_ctrl_if bus();

  aes_ctr_ctrl #(.CTR_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .init_ctr_i   (init_ctr),
    .num_blocks_i (num_blocks),
    .key_ready_i  (key_ready),
`ifdef AES_CTR_ABORT_EN
    .abort_i      (abort),
`endif
    .bus          (bus),
    .ctr_value_o  (ctr_value),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int nxt_cnt = 0;
  int out_cnt = 0;
  bit src_hold = 1'b0;
  bit sink_hold = 1'b0;
  logic [7:0]   sbox [256];
  logic [127:0] key;
  logic [127:0] exp_q [$];
  logic [127:0] src_q [$];
  logic [127:0] blk_log [$];

  logic [127:0] nist_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] nist_ct [4] = '{128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
                                128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] st [16];
    logic [7:0] tmp [16];
    logic [7:0] t [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
      if (i % 16 == 0) begin
        a0 = t[0];
        t[0] = sbox[t[1]] ^ rc;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[a0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) tmp[rr+4*c] = sbox[st[rr+4*((c+rr)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (rnd < 10) begin
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
    return r;
  endfunction

  // Nonce stays put, the low CW bits count modulo 2^CW.
  function automatic logic [127:0] ctr_at(input logic [127:0] init, input int i);
    return {init[127:CW], init[CW-1:0] + CW'(i)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    n_chk++;
    if (got) n_pass++;
    else $display("FAIL %s: done not seen within %0d cycles", name, budget);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input string name, input int k);
    int seen;
    seen = 0;
    for (int i = 0; i < 400 && seen < k; i++) begin
      @(negedge clk);
      if (bus.enc_next) seen++;
    end
    if (seen < k) begin
      n_chk++;
      $display("FAIL %s: saw %0d launches, expected %0d", name, seen, k);
    end
  endtask

  task automatic start_job(input logic [127:0] init, input int n, input bit nist);
    logic [127:0] pt;
    for (int i = 0; i < n; i++) begin
      pt = nist ? nist_pt[i] : {$urandom, $urandom, $urandom, $urandom};
      src_q.push_back(pt);
      exp_q.push_back(nist ? nist_ct[i] : pt ^ aes_enc(key, ctr_at(init, i)));
    end
    init_ctr   = init;
    num_blocks = 16'(n);
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  // Encipher model: ready drops the edge after next, result appears with ready.
  initial begin
    int cnt;
    bit pend;
    logic [127:0] blk;
    cnt = 0;
    pend = 1'b0;
    blk = '0;
    bus.enc_ready  = 1'b1;
    bus.enc_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        bus.enc_ready = 1'b0;
        cnt  = $urandom_range(3, 10);
        pend = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.enc_result = aes_enc(key, blk);
          bus.enc_ready  = 1'b1;
        end
      end
      if (bus.enc_next) begin
        pend = 1'b1;
        blk  = bus.enc_block;
      end
    end
  end

  initial begin
    bit fire;
    int gap;
    gap = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready && !reset;
      @(posedge clk);
      #1;
      if (fire) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        bus.in_valid = 1'b0;
        gap = $urandom_range(0, 3);
      end
      if (!bus.in_valid && src_q.size() > 0 && !src_hold) begin
        if (gap > 0) gap--;
        else begin
          bus.in_valid = 1'b1;
          bus.in_data  = src_q[0];
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = sink_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every output handshake is checked against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done) done_cnt++;
        if (bus.enc_next) begin
          nxt_cnt++;
          blk_log.push_back(bus.enc_block);
        end
        if (bus.out_valid && bus.out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got %h, expected no output", bus.out_data);
          end else begin
            chk("out_data", bus.out_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] init;
    logic [7:0] inv, s;
    int d0, n0, c0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
      sbox[x] = s ^ 8'h63;
    end
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    cyc(3);
    @(negedge clk);
    chk("rst_ctr", ctr_value, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_ctl", {busy, done, bus.in_ready, bus.out_valid, bus.enc_next}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(2);

    key_ready = 1'b0;
    n0 = nxt_cnt;
    init_ctr = 128'h55; num_blocks = 16'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("nokey_busy", busy, 0);
    chk("nokey_ctr", ctr_value, 0);
    chk("nokey_launch", nxt_cnt - n0, 0);
    key_ready = 1'b1;

    d0 = done_cnt;
    start_job(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 4, 1'b1);
    wait_done("nist_done", 400);
    cyc(3);
    chk("nist_done_once", done_cnt - d0, 1);
    chk("nist_drain", exp_q.size(), 0);

    for (int j = 0; j < 4; j++) begin
      key  = {$urandom, $urandom, $urandom, $urandom};
      init = {$urandom, $urandom, $urandom, $urandom};
      if (j[0]) init[31:0] = 32'hffff_fffe;
      start_job(init, $urandom_range(1, 5), 1'b0);
      wait_done("rand_done", 600);
      chk("rand_drain", exp_q.size(), 0);
    end

    blk_log.delete();
    init = 128'h0123456789abcdef01234567ffffffff;
    start_job(init, 2, 1'b0);
    wait_done("wrap_done", 300);
    chk("wrap_launches", blk_log.size(), 2);
    if (blk_log.size() >= 2) chk("wrap_blk1", blk_log[1], 128'h0123456789abcdef0123456700000000);
    chk("wrap_ctr", ctr_value, 128'h0123456789abcdef0123456700000001);

    n0 = nxt_cnt;
    init_ctr = 128'h1234; num_blocks = 16'd0; start = 1'b1;
    @(negedge clk);
    chk("zero_c0", {busy, done}, 2'b00);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_c1", {busy, done}, 2'b01);
    @(negedge clk);
    chk("zero_c2", {busy, done}, 2'b00);
    chk("zero_nolaunch", nxt_cnt - n0, 0);
    chk("zero_ctr", ctr_value, 128'h1234);
    cyc(1);

    sink_hold = 1'b1;
    cyc(1);
    start_job({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        got = bus.out_valid;
      end
      chk("bp_valid_seen", got, 1);
    end
    n0 = nxt_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      if (exp_q.size() > 0) chk("bp_data", bus.out_data, exp_q[0]);
    end
    chk("bp_no_launch", nxt_cnt - n0, 0);
    @(posedge clk);
    #1;
    sink_hold = 1'b0;
    wait_done("bp_done", 300);
    chk("bp_drain", exp_q.size(), 0);

    src_hold = 1'b1;
    start_job({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    wait_launch("late_launch", 1);
    @(negedge clk);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        got = bus.enc_ready;
      end
      chk("late_ready_seen", got, 1);
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      src_hold = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = bus.in_valid && bus.in_ready;
      end
      chk("late_xfer_seen", got, 1);
      chk("late_ov_before", bus.out_valid, 0);
      @(negedge clk);
      chk("late_ov_after", bus.out_valid, 1);
    end
    wait_done("late_done", 200);
    chk("late_drain", exp_q.size(), 0);

    start_job({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);
    wait_launch("rst_launch2", 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {busy, done, bus.in_ready, bus.out_valid, bus.enc_next}, 0);
    chk("midrst_ctr", ctr_value, 0);
    chk("midrst_out_data", bus.out_data, 0);
    exp_q.delete();
    src_q.delete();
    bus.in_valid = 1'b0;
    cyc(20);
    init = {$urandom, $urandom, $urandom, $urandom};
    start_job(init, 1, 1'b0);
    wait_done("post_rst_done", 200);
    chk("post_rst_drain", exp_q.size(), 0);
    chk("post_rst_ctr", ctr_value, ctr_at(init, 1));

`ifdef AES_CTR_ABORT_EN
    src_hold = 1'b1;
    c0 = out_cnt;
    d0 = done_cnt;
    n0 = nxt_cnt;
    init = {$urandom, $urandom, $urandom, $urandom};
    init_ctr = init; num_blocks = 16'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_launch("abort_launch", 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_done("abort_done", 100);
    cyc(3);
    chk("abort_no_out", out_cnt - c0, 0);
    chk("abort_done_once", done_cnt - d0, 1);
    chk("abort_one_launch", nxt_cnt - n0, 1);
    chk("abort_ctr", ctr_value, init);
    chk("abort_idle", busy, 0);
    src_hold = 1'b0;
`else
    c0 = out_cnt;
    chk("final_idle", {busy, bus.out_valid}, 0);
    chk("final_outs_quiet", out_cnt - c0, 0);
`endif

    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
